// File: rtl/recon_block_scheduler.sv
// Reconstruction sequencer for one 4:2:0 macroblock: 16 Y, 4 Cb, 4 Cr 4x4 blocks.
// Optional stall counter is built only when RECON_SCHED_PERF_EN is defined.
//
// state   | meaning
// IDLE    | waiting for mb_start
// WAIT    | waiting for prediction and residual of blk_idx
// SUM     | one-cycle sum strobe into the reconstruction stage
// WRITE   | reconstructed block offered to the writer; next prediction may be prefetched
// DONE    | one-cycle mb_done pulse
module recon_block_scheduler #(
    parameter int LUMA_BLKS   = 16,
    parameter int CHROMA_BLKS = 8,
    parameter int PERF_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mb_start,
    input  logic              mb_intra4x4,
    output logic              busy,
    output logic              pred_req,
    output logic [4:0]        pred_idx,
    input  logic              pred_valid,
    output logic              pred_ack,
    input  logic              res_valid,
    input  logic              res_zero,
    output logic              res_ack,
    output logic              sum_en,
    output logic [4:0]        blk_idx,
    output logic [1:0]        blk_comp,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic              mb_done,
    output logic [PERF_W-1:0] stall_cnt
);

    localparam logic [4:0] LAST_BLK   = 5'(LUMA_BLKS + CHROMA_BLKS - 1);
    localparam logic [4:0] LAST_LUMA  = 5'(LUMA_BLKS - 1);
    localparam logic [4:0] FIRST_CB   = 5'(LUMA_BLKS);
    localparam logic [4:0] FIRST_CR   = 5'(LUMA_BLKS + CHROMA_BLKS / 2);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SUM, S_WRITE, S_DONE} state_t;

    state_t     state, state_n;
    logic [4:0] blk_n, pidx_n;
    logic       pf, pf_n, intra, intra_n;
    logic       pack_n, sum_n, req_n, pf_allow_n, ops_ready;

    function automatic logic [1:0] comp_of(input logic [4:0] b);
        if (b < FIRST_CB)      return 2'd0;
        else if (b < FIRST_CR) return 2'd1;
        else                   return 2'd2;
    endfunction

    assign ops_ready = (pf || pred_valid) && (res_valid || res_zero);

    always_comb begin
        state_n = state;
        blk_n   = blk_idx;
        pf_n    = pf;
        intra_n = intra;
        pack_n  = 1'b0;
        sum_n   = 1'b0;
        case (state)
            S_IDLE: if (mb_start) begin
                state_n = S_WAIT;
                blk_n   = '0;
                pf_n    = 1'b0;
                intra_n = mb_intra4x4;
            end
            S_WAIT: if (ops_ready) begin
                state_n = S_SUM;
                sum_n   = 1'b1;
                pack_n  = !pf;
            end
            S_SUM: begin
                pf_n    = 1'b0;
                state_n = S_WRITE;
            end
            S_WRITE: begin
                // prefetch ack and write handshake may land on the same edge
                if (pred_req && pred_valid) begin
                    pf_n   = 1'b1;
                    pack_n = 1'b1;
                end
                if (wr_ready) begin
                    if (blk_idx == LAST_BLK) begin
                        state_n = S_DONE;
                    end else begin
                        blk_n   = blk_idx + 5'd1;
                        state_n = S_WAIT;
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // intra 4x4 luma must see the neighbours written before the next request
    assign pf_allow_n = !intra_n || (blk_n >= LAST_LUMA);
    assign req_n = ((state_n == S_WAIT) && !pf_n) ||
                   ((state_n == S_WRITE) && pf_allow_n && (blk_n != LAST_BLK) && !pf_n);
    assign pidx_n = ((state_n == S_WRITE) && (blk_n != LAST_BLK)) ? blk_n + 5'd1 : blk_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            blk_idx  <= '0;
            pf       <= 1'b0;
            intra    <= 1'b0;
            busy     <= 1'b0;
            pred_req <= 1'b0;
            pred_idx <= '0;
            pred_ack <= 1'b0;
            res_ack  <= 1'b0;
            sum_en   <= 1'b0;
            wr_valid <= 1'b0;
            mb_done  <= 1'b0;
            blk_comp <= '0;
        end else begin
            state    <= state_n;
            blk_idx  <= blk_n;
            pf       <= pf_n;
            intra    <= intra_n;
            busy     <= (state_n != S_IDLE);
            pred_req <= req_n;
            pred_idx <= pidx_n;
            pred_ack <= pack_n;
            res_ack  <= sum_n;
            sum_en   <= sum_n;
            wr_valid <= (state_n == S_WRITE);
            mb_done  <= (state_n == S_DONE);
            blk_comp <= comp_of(blk_n);
        end
    end

`ifdef RECON_SCHED_PERF_EN
    logic [PERF_W-1:0] stall_q;
    logic              stalled;

    assign stalled   = ((state == S_WAIT) && !ops_ready) || ((state == S_WRITE) && !wr_ready);
    assign stall_cnt = stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if ((state == S_IDLE) && mb_start) begin
            stall_q <= '0;
        end else if (stalled && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_recon_block_scheduler.sv
// Directed bench for recon_block_scheduler: inter, intra4x4, res_zero, writer backpressure,
// mid-macroblock reset and the optional stall counter.
module tb_recon_block_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mb_start = 1'b0, mb_intra4x4 = 1'b0;
    logic        pred_valid = 1'b0, res_valid = 1'b1, res_zero = 1'b0, wr_ready = 1'b1;
    logic        busy, pred_req, pred_ack, res_ack, sum_en, wr_valid, mb_done;
    logic [4:0]  pred_idx, blk_idx;
    logic [1:0]  blk_comp;
    logic [15:0] stall_cnt;

    recon_block_scheduler dut (
        .clk(clk), .reset(reset), .mb_start(mb_start), .mb_intra4x4(mb_intra4x4),
        .busy(busy), .pred_req(pred_req), .pred_idx(pred_idx), .pred_valid(pred_valid),
        .pred_ack(pred_ack), .res_valid(res_valid), .res_zero(res_zero), .res_ack(res_ack),
        .sum_en(sum_en), .blk_idx(blk_idx), .blk_comp(blk_comp), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .mb_done(mb_done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;
    int auto_pdelay = 0, pcnt = 0, late_left = 0;
    int hold_blk = -1, hold_left = 0, zero_blk = -1;
    int n_sum, n_wr, n_pack, n_rack, n_viol, comp_err, idx_err, gap_err;
    int last_sum, last_wr_cyc, done_cyc, wv3, pack_w3, pack_s4, rack_z;
    int n_done_total = 0;
    bit saw16, gap_chk = 0, intra_tb = 0, seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one clock: sample after the edge, update responder inputs, collect statistics
    task automatic tick();
        int ec;
        @(posedge clk); #1; cyc++;
        if (hold_left > 0 && wr_valid && int'(blk_idx) == hold_blk) begin
            wr_ready = 1'b0; hold_left--;
        end else wr_ready = 1'b1;
        res_zero  = busy && (int'(blk_idx) == zero_blk);
        res_valid = !res_zero;
        if (late_left > 0 && pred_req) begin
            pred_valid = 1'b0; late_left--;
        end else if (auto_pdelay > 0) begin
            if (pred_ack) begin pred_valid = 1'b0; pcnt = 0; end
            else if (pred_req) begin pcnt++; if (pcnt >= auto_pdelay) pred_valid = 1'b1; end
        end else pred_valid = 1'b1;

        if (sum_en) begin
            if (gap_chk && last_sum >= 0 && cyc - last_sum != 3) gap_err++;
            last_sum = cyc; n_sum++;
            if (int'(blk_idx) == zero_blk) rack_z = int'(res_ack);
            if (blk_idx == 5'd4 && pred_ack) pack_s4++;
        end
        if (res_ack) n_rack++;
        if (pred_ack) n_pack++;
        if (wr_valid) begin
            if (blk_idx == 5'd3) wv3++;
            if (blk_idx == 5'd3 && pred_ack) pack_w3++;
            if (intra_tb && blk_idx < 5'd15 && pred_req) n_viol++;
            if (blk_idx == 5'd15 && pred_req && pred_idx == 5'd16) saw16 = 1'b1;
            if (pred_req && int'(pred_idx) != int'(blk_idx) + 1) idx_err++;
            if (wr_ready) begin
                ec = (n_wr < 16) ? 0 : (n_wr < 20) ? 1 : 2;
                if (int'(blk_idx) != n_wr || int'(blk_comp) != ec) comp_err++;
                n_wr++; last_wr_cyc = cyc;
            end
        end else if (pred_req && pred_idx != blk_idx) idx_err++;
        if (mb_done) begin n_done_total++; done_cyc = cyc; end
    endtask

    task automatic start_mb(input bit intra);
        n_sum = 0; n_wr = 0; n_pack = 0; n_rack = 0; n_viol = 0; comp_err = 0; idx_err = 0;
        gap_err = 0; last_sum = -1; last_wr_cyc = 0; done_cyc = 0; wv3 = 0; pack_w3 = 0;
        pack_s4 = 0; rack_z = -1; saw16 = 1'b0; intra_tb = intra; seen = 1'b0;
        mb_intra4x4 = intra; mb_start = 1'b1;
        tick();
        mb_start = 1'b0; mb_intra4x4 = 1'b0;
    endtask

    task automatic finish_mb();
        for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            if (mb_done) seen = 1'b1;
        end
        check("mb_done_seen", 32'(seen), 32'd1);
    endtask

    int done_before, exp_stall;

    initial begin
        // reset state
        tick(); tick();
        check("rst_outputs", 32'({busy, pred_req, pred_ack, res_ack, sum_en, wr_valid, mb_done,
                                  blk_idx, pred_idx, blk_comp}), 32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        reset = 1'b0;
        tick();

        // inter macroblock, operands and writer always ready
        gap_chk = 1'b1;
        start_mb(1'b0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_first_req", 32'({pred_req, pred_idx}), 32'({1'b1, 5'd0}));
        finish_mb();
        gap_chk = 1'b0;
        check("t1_sum", n_sum, 24);
        check("t1_wr", n_wr, 24);
        check("t1_comp_seq", comp_err, 0);
        check("t1_pred_idx", idx_err, 0);
        check("t1_period3", gap_err, 0);
        check("t1_done_lat", done_cyc - last_wr_cyc, 1);
        check("t1_pack", n_pack, 24);
        check("t1_rack", n_rack, 24);
        check("t1_busy_done", 32'(busy), 32'd1);
        mb_start = 1'b1;
        tick();
        mb_start = 1'b0;
        tick();
        check("t1_start_in_done_ignored", 32'(busy), 32'd0);

        // intra 4x4, prediction arrives 2 cycles after each request
        pred_valid = 1'b0; auto_pdelay = 2; pcnt = 0;
        start_mb(1'b1);
        finish_mb();
        auto_pdelay = 0;
        check("t2_no_req_in_luma_write", n_viol, 0);
        check("t2_prefetch_16", 32'(saw16), 32'd1);
        check("t2_wr", n_wr, 24);
        check("t2_pack", n_pack, 24);
        check("t2_comp_seq", comp_err, 0);
        check("t2_pred_idx", idx_err, 0);
        tick(); tick();

        // res_zero on block 5, writer stalled 4 cycles on block 3
        zero_blk = 5; hold_blk = 3; hold_left = 4;
        start_mb(1'b0);
        finish_mb();
        zero_blk = -1;
        check("t3_rack_blk5", rack_z, 1);
        check("t3_rack", n_rack, 24);
        check("t4_wrvalid_blk3", wv3, 5);
        check("t4_prefetch_ack_once", pack_w3, 1);
        check("t4_no_second_ack", pack_s4, 0);
        check("t4_pack", n_pack, 24);
        check("t4_wr", n_wr, 24);
        check("t4_comp_seq", comp_err, 0);
        tick(); tick();

        // reset while block 10 is in WRITE
        done_before = n_done_total;
        start_mb(1'b0);
        for (int i = 0; i < 200 && !(wr_valid && blk_idx == 5'd10); i++) tick();
        check("t5_reached_blk10", 32'({wr_valid, blk_idx}), 32'({1'b1, 5'd10}));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rst_outputs", 32'({busy, pred_req, pred_ack, res_ack, sum_en, wr_valid, mb_done,
                                     blk_idx, pred_idx, blk_comp}), 32'd0);
        tick(); tick(); tick();
        check("t5_idle_after_rst", 32'({busy, pred_req}), 32'd0);
        check("t5_no_done_aborted", n_done_total - done_before, 0);
        start_mb(1'b0);
        check("t5_restart_blk0", 32'({busy, blk_idx}), 32'({1'b1, 5'd0}));
        finish_mb();
        check("t5_restart_wr", n_wr, 24);
        check("t5_restart_seq", comp_err, 0);
        check("t5_one_done", n_done_total - done_before, 1);
        tick(); tick();

        // stall accounting: 3 late prediction cycles plus 7 writer-stall cycles
        pred_valid = 1'b0; late_left = 3; hold_blk = 8; hold_left = 7;
        start_mb(1'b0);
        finish_mb();
`ifdef RECON_SCHED_PERF_EN
        exp_stall = 10;
`else
        exp_stall = 0;
`endif
        check("t6_stall_at_done", 32'(stall_cnt), 32'(exp_stall));
        tick(); tick();
        check("t6_stall_held", 32'(stall_cnt), 32'(exp_stall));
        check("t6_wr", n_wr, 24);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/recon_block_scheduler.md
Name: recon_block_scheduler

Overview:
- Sequences the sample reconstruction stage across one macroblock: 16 luma 4x4 blocks, then 4 Cb and 4 Cr 4x4 blocks (4:2:0).
- Each step waits for the prediction and IDCT residual operands, fires the one-cycle sum strobe into the reconstruction stage, then hands the registered 4x4 result to the picture/neighbour buffer writer.
- Enforces the intra 4x4 dependency: the next block is requested only after the current block is written.
- For all other modes it prefetches the next block's prediction while the current block is being written.

Parameters:
- LUMA_BLKS, 16, luma 4x4 blocks per macroblock.
- CHROMA_BLKS, 8, chroma 4x4 blocks per macroblock (4 Cb + 4 Cr).
- PERF_W, 16, width of the stall counter (optional feature only).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- mb_start  in  1  one-cycle pulse that starts a macroblock; sampled only in IDLE.
- mb_intra4x4  in  1  latched at mb_start; 1 = serialise luma blocks (no prefetch).
- busy  out  1  high from the cycle after an accepted mb_start until mb_done.
- pred_req  out  1  level request for the prediction of pred_idx.
- pred_idx  out  5  block index (0..23) of the prediction being requested.
- pred_valid  in  1  level; prediction for pred_idx is available; held until pred_ack.
- pred_ack  out  1  one-cycle pulse; consumes the prediction.
- res_valid  in  1  level; IDCT output for blk_idx is available; held until res_ack.
- res_zero  in  1  current block has no coded residual; substitutes for res_valid.
- res_ack  out  1  one-cycle pulse; consumes the residual (asserted even when res_zero).
- sum_en  out  1  one-cycle strobe; the reconstruction stage registers its output on this edge.
- blk_idx  out  5  block currently being reconstructed.
- blk_comp  out  2  component of blk_idx: 0 = Y, 1 = Cb, 2 = Cr.
- wr_valid  out  1  reconstructed 4x4 block is ready for the writer.
- wr_ready  in  1  writer accepts when wr_valid && wr_ready.
- mb_done  out  1  one-cycle pulse after block 23 is written.
- stall_cnt  out  PERF_W  optional; see Optional Feature.

Behaviour:
- Reset (synchronous, active-high, takes priority in any state):
  - state returns to IDLE; blk_idx = 0; prefetch flag cleared.
  - busy, pred_req, pred_ack, res_ack, sum_en, wr_valid and mb_done all go to 0.
  - pred_idx = 0; blk_comp = 0.
  - A reset mid-macroblock abandons it; no mb_done is issued.
- blk_comp is 0 for blk_idx 0..15, 1 for 16..19 and 2 for 20..23.
- IDLE:
  - On mb_start: latch mb_intra4x4, set blk_idx = 0, go to WAIT.
  - mb_start in any other state is ignored.
- WAIT:
  - pred_req = 1 and pred_idx = blk_idx, unless the prefetch flag shows the prediction was already acknowledged.
  - Operands are ready when the prediction is satisfied (pred_valid, or the prefetch flag is set) and (res_valid || res_zero). The next state is SUM.
- SUM (exactly 1 cycle):
  - sum_en = 1 and res_ack = 1.
  - pred_ack = 1 unless the prefetch flag is set; the prefetch flag is cleared.
  - Next state is WRITE.
  - Latency from operands ready to wr_valid is 2 cycles.
- WRITE:
  - wr_valid = 1 and stays high until the handshake.
  - On wr_valid && wr_ready: if blk_idx == 23 go to DONE, else blk_idx increments and go to WAIT.
  - Prefetch (mb_intra4x4 == 0, or blk_idx >= 15 so the next block is chroma or none): while blk_idx < 23, pred_req = 1 and pred_idx = blk_idx + 1.
  - On pred_valid in WRITE: pulse pred_ack and set the prefetch flag.
  - If the prefetch ack and the write handshake happen in the same cycle, both take effect.
  - In intra4x4 luma (blk_idx < 15), pred_req = 0 during WRITE. This guarantees the neighbour samples are written before the next prediction is requested.
- DONE (1 cycle): mb_done = 1, busy = 0 from the next cycle, go to IDLE.
  - mb_start in the DONE cycle is ignored; a new mb_start is accepted from the first IDLE cycle.
- pred_ack and res_ack never assert in the same cycle as reset or in IDLE.

Optional Feature:
- Macro: RECON_SCHED_PERF_EN.
- Defined:
  - stall_cnt counts cycles in WAIT or WRITE with the handshake not satisfied.
  - It is cleared on an accepted mb_start and on reset, and saturates at all-ones.
  - It is held after mb_done until the next mb_start.
- Undefined: stall_cnt is tied to 0 and no counter logic is built.

Test Plan:
- Inter macroblock; pred_valid, res_valid and wr_ready tied to 1 -> block period is 3 cycles after the first block; sum_en pulses 24 times; mb_done one cycle after the 24th write; blk_comp sequence is 16x0, 4x1, 4x2.
- mb_intra4x4 = 1; pred_valid asserted 2 cycles after each pred_req -> pred_req is never high during WRITE for blk_idx 0..14; prefetch resumes at blk_idx 15 (pred_idx = 16); 24 writes total.
- res_zero = 1 and res_valid = 0 for blk_idx 5 -> the block still reconstructs; res_ack pulses in its SUM cycle.
- wr_ready held low 4 cycles on blk_idx 3 -> wr_valid stays high 5 cycles; blk_idx stays 3; a prefetch ack for pred_idx 4 occurs once; blk 4 SUM issues no second pred_ack.
- reset pulsed while blk_idx = 10 in WRITE -> the next cycle all outputs are 0 and state is IDLE; a fresh mb_start restarts at blk_idx 0; no mb_done for the aborted macroblock.
- RECON_SCHED_PERF_EN defined; wr_ready low 7 cycles once and pred_valid late 3 cycles once -> stall_cnt = 10 at mb_done.
